// File: rtl/control_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : control_sequencer
//  Description : Multi-cycle control unit for a small accumulator machine.
//                Fetches an instruction from memory into IR, then sequences
//                the memory strobes and accumulator commands that execute it.
//                Instruction format: IR[7:5] opcode, IR[4:0] operand address.
//
//  Ports
//    CLK              in   single clock, rising-edge active
//    RST              in   asynchronous active-high reset
//    start            in   level; leaves HALT when sampled high
//    Dbus     [W-1:0] in   shared data bus, observed only (instruction fetch)
//    acc_zero         in   accumulator == 0 flag
//    acc_neg          in   accumulator < 0 flag
//    Abus     [A-1:0] out  memory address
//    Ain              out  latch Abus into the memory address register
//    read             out  memory read strobe
//    Dout             out  memory drives Dbus
//    Din              out  memory samples Dbus
//    write            out  memory write strobe
//    acc_load         out  accumulator <= Dbus
//    acc_add          out  accumulator <= accumulator + Dbus
//    acc_sub          out  accumulator <= accumulator - Dbus
//    acc_out          out  accumulator drives Dbus
//    PC       [A-1:0] out  program counter
//    IR       [W-1:0] out  instruction register
//    halted           out  high only in HALT
//
//  Revision    : 1.0  initial release
// ============================================================================
module control_sequencer #(
    parameter int WORD_WIDTH    = 8,
    parameter int ADDRESS_WIDTH = 5
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     start,
    input  logic [WORD_WIDTH-1:0]    Dbus,
    input  logic                     acc_zero,
    input  logic                     acc_neg,
    output logic [ADDRESS_WIDTH-1:0] Abus,
    output logic                     Ain,
    output logic                     read,
    output logic                     Dout,
    output logic                     Din,
    output logic                     write,
    output logic                     acc_load,
    output logic                     acc_add,
    output logic                     acc_sub,
    output logic                     acc_out,
    output logic [ADDRESS_WIDTH-1:0] PC,
    output logic [WORD_WIDTH-1:0]    IR,
    output logic                     halted
);

    // Opcode field occupies the bits above the address field; the
    // instruction set below is defined for exactly three opcode bits.
    localparam int OPCODE_WIDTH = WORD_WIDTH - ADDRESS_WIDTH;

    localparam logic [2:0] OP_STP = 3'b000;  // stop
    localparam logic [2:0] OP_DOD = 3'b001;  // add
    localparam logic [2:0] OP_ODE = 3'b010;  // subtract
    localparam logic [2:0] OP_POB = 3'b011;  // load
    localparam logic [2:0] OP_LAD = 3'b100;  // store
    localparam logic [2:0] OP_SOB = 3'b101;  // jump
    localparam logic [2:0] OP_SOM = 3'b110;  // jump if negative
    localparam logic [2:0] OP_SOZ = 3'b111;  // jump if zero

    typedef enum logic [2:0] {
        HALT    = 3'd0,
        FETCH_A = 3'd1,
        FETCH_R = 3'd2,
        EXEC_A  = 3'd3,
        EXEC_D  = 3'd4,
        EXEC_W  = 3'd5
    } state_t;

    state_t                     state_q, state_d;
    logic [ADDRESS_WIDTH-1:0]   pc_q, pc_d;
    logic [WORD_WIDTH-1:0]      ir_q, ir_d;

    logic [OPCODE_WIDTH-1:0]    opcode_w;
    logic [ADDRESS_WIDTH-1:0]   operand_w;

    assign opcode_w  = ir_q[WORD_WIDTH-1:ADDRESS_WIDTH];
    assign operand_w = ir_q[ADDRESS_WIDTH-1:0];

    // ------------------------------------------------------------------
    // State, PC and IR registers
    // ------------------------------------------------------------------
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= HALT;
            pc_q    <= '0;
            ir_q    <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;

        case (state_q)
            HALT: begin
                if (start) begin
                    state_d = FETCH_A;
                end
            end

            FETCH_A: begin
                // Natural width wrap gives the modulo-2^A increment.
                pc_d    = pc_q + 1'b1;
                state_d = FETCH_R;
            end

            FETCH_R: begin
                ir_d    = Dbus;
                state_d = EXEC_A;
            end

            EXEC_A: begin
                case (opcode_w)
                    OP_STP: state_d = HALT;
                    OP_DOD,
                    OP_ODE,
                    OP_POB,
                    OP_LAD: state_d = EXEC_D;
                    OP_SOB: begin
                        pc_d    = operand_w;
                        state_d = FETCH_A;
                    end
                    OP_SOM: begin
                        if (acc_neg) begin
                            pc_d = operand_w;
                        end
                        state_d = FETCH_A;
                    end
                    OP_SOZ: begin
                        if (acc_zero) begin
                            pc_d = operand_w;
                        end
                        state_d = FETCH_A;
                    end
                    default: state_d = HALT;
                endcase
            end

            EXEC_D: begin
                // Store needs an extra cycle to write the driven value.
                if (opcode_w == OP_LAD) begin
                    state_d = EXEC_W;
                end else begin
                    state_d = FETCH_A;
                end
            end

            EXEC_W: begin
                state_d = FETCH_A;
            end

            default: begin
                state_d = HALT;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Moore output decode from state and IR
    // ------------------------------------------------------------------
    always_comb begin
        Abus     = pc_q;
        Ain      = 1'b0;
        read     = 1'b0;
        Dout     = 1'b0;
        Din      = 1'b0;
        write    = 1'b0;
        acc_load = 1'b0;
        acc_add  = 1'b0;
        acc_sub  = 1'b0;
        acc_out  = 1'b0;

        case (state_q)
            FETCH_A: begin
                Ain = 1'b1;
            end

            FETCH_R: begin
                read = 1'b1;
                Dout = 1'b1;
            end

            EXEC_A: begin
                case (opcode_w)
                    OP_DOD,
                    OP_ODE,
                    OP_POB,
                    OP_LAD: begin
                        Abus = operand_w;
                        Ain  = 1'b1;
                    end
                    default: begin
                        Abus = pc_q;
                    end
                endcase
            end

            EXEC_D: begin
                case (opcode_w)
                    OP_DOD: begin
                        read    = 1'b1;
                        Dout    = 1'b1;
                        acc_add = 1'b1;
                    end
                    OP_ODE: begin
                        read    = 1'b1;
                        Dout    = 1'b1;
                        acc_sub = 1'b1;
                    end
                    OP_POB: begin
                        read     = 1'b1;
                        Dout     = 1'b1;
                        acc_load = 1'b1;
                    end
                    OP_LAD: begin
                        // Accumulator drives the bus; memory must not.
                        acc_out = 1'b1;
                        Din     = 1'b1;
                    end
                    default: begin
                        Abus = pc_q;
                    end
                endcase
            end

            EXEC_W: begin
                Abus  = operand_w;
                write = 1'b1;
            end

            default: begin
                Abus = pc_q;
            end
        endcase
    end

    assign halted = (state_q == HALT);
    assign PC     = pc_q;
    assign IR     = ir_q;

endmodule
`default_nettype wire
